weights_responder: RTL
======================

Name: weights_responder

Overview:
Avalon-MM responder that stores one neuron's outgoing weights (layer l+1) and serves read requests from the previous layer's error calculators during backpropagation. Each previous-layer neuron drives one slave port.
- Reads are arbitrated round-robin, one per cycle, with a fixed 1-cycle read latency.
- A weight-update write port has priority over reads.
- A sticky IRQ flags out-of-range addresses.

Parameters:
- G_WEIGHT_WIDTH, 18, signed weight width.
- G_NUM_OF_WEIGHTS, 4, number of stored weights; legal addresses 0..G_NUM_OF_WEIGHTS-1.
- G_NUM_OF_PORTS, 4, number of Avalon-MM slave ports (one per previous-layer neuron).
- G_ADDR_WIDTH, 8, Avalon address width; must be at least log2up(G_NUM_OF_WEIGHTS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- weights_resp_arr_mm[G_NUM_OF_PORTS-1:0]  avalon_mm_if.slave. Per port:
  - address in G_ADDR_WIDTH
  - read in 1
  - waitreq out 1
  - read_data out G_WEIGHT_WIDTH
  - read_data_valid out 1
- w_wr_valid  in  1  weight update strobe.
- w_wr_idx  in  log2up(G_NUM_OF_WEIGHTS)  weight index to update.
- w_wr_data  in  G_WEIGHT_WIDTH  new signed weight.
- irq_clr  in  1  clears irq_bad_addr.
- irq_bad_addr  out  1  sticky; set on an accepted read with address >= G_NUM_OF_WEIGHTS.

Behaviour:
- Storage: register array weights[G_NUM_OF_WEIGHTS]; all entries 0 after reset.
- Reset values:
  - waitreq = 1 on all ports (combinational; see below).
  - read_data = 0, read_data_valid = 0.
  - RR pointer = 0.
  - irq_bad_addr = 0.
- Write:
  - When w_wr_valid=1, weights[w_wr_idx] <= w_wr_data at the clock edge.
  - w_wr_idx >= G_NUM_OF_WEIGHTS: write ignored and irq_bad_addr set.
- Arbitration (combinational, single cycle):
  - req[p] = read[p].
  - If w_wr_valid=1, gnt = 0 (write priority; all reads stalled).
  - Otherwise grant exactly one requesting port: the first set req[] bit searching from ptr upward, wrapping modulo G_NUM_OF_PORTS.
  - waitreq[p] = ~gnt[p], so an idle port sees waitreq=1.
  - A transfer is accepted on port p when read[p] & ~waitreq[p].
- Pointer update: on an accepted grant to p, ptr <= (p+1) mod G_NUM_OF_PORTS. With no grant, ptr holds.
- Read response, latency 1:
  - The cycle after acceptance on p: read_data_valid[p]=1 for exactly one cycle.
  - read_data[p] = weights[address] as sampled at acceptance. The data value is sampled from array contents after any write in an earlier cycle; no same-cycle write can occur because writes block grants.
  - read_data of other ports holds its last value; read_data_valid of other ports = 0.
- Out-of-range read (address >= G_NUM_OF_WEIGHTS):
  - Still accepted and answered with read_data=0, read_data_valid=1.
  - irq_bad_addr <= 1.
- irq_clr:
  - Clears irq_bad_addr.
  - If a new bad-address event occurs in the same cycle, set wins.
- Masters must hold address/read stable while waitreq=1 (Avalon rule). The responder keeps no per-port state beyond the response registers.
- Back-to-back: one port re-requesting every cycle is granted every cycle if it is the only requester, giving one response per cycle.
- Throughput with all ports requesting: each port is served once per G_NUM_OF_PORTS cycles.
- rst mid-operation: any pending read_data_valid is dropped, the pointer returns to 0 and weights clear. Masters must reissue their reads.
- G_NUM_OF_PORTS=1: the arbiter degenerates to gnt = read & ~w_wr_valid.

Decomposition:
- Package weights_pack:
  - typedef weight_t = logic signed [G_WEIGHT_WIDTH-1:0].
  - Constant C_WIDX_WIDTH = log2up(G_NUM_OF_WEIGHTS).
  - Helper function rr_next(ptr, n).
- Sub-module rr_arbiter:
  - Parameter G_N.
  - Inputs: req[G_N], enable, clk/rst.
  - Outputs: one-hot gnt[G_N].
  - Owns the pointer and its update on accept.
- Top: storage, response registers, IRQ logic, per-port interface-to-vector assigns.

Test Plan:
- Reset, then write idx0..3 with 5, -3, 100, -131072; port1 reads address 2 -> next cycle read_data_valid[1]=1 with read_data=100; other ports' read_data_valid=0.
- All 4 ports read address 1 (value -3) from ptr=0 -> grants in order 0,1,2,3 on consecutive cycles; each port gets read_data=-3 exactly once; waitreq held on the waiting ports.
- Port 2 reads while w_wr_valid=1 (idx 2 <= 7) for 2 cycles -> waitreq[2]=1 both cycles; accepted on cycle 3 with read_data=7.
- Port 0 reads address 4 (G_NUM_OF_WEIGHTS=4) -> read_data=0, read_data_valid=1, irq_bad_addr=1 and stays set. irq_clr pulse -> 0. irq_clr in the same cycle as a new bad read -> irq_bad_addr stays 1.
- Ports 0 and 3 request continuously with ptr=3 -> grants alternate 3,0,3,0; no starvation over 20 cycles.
- rst asserted the cycle after an accept -> read_data_valid=0 the next cycle, all weights read back as 0, ptr=0.

Source files
------------

// File: rtl/weights_responder_pkg.sv
// Shared types, default sizes and helpers for the weights responder
// and its round-robin arbiter.
package weights_pack;

    localparam int C_DEF_WEIGHT_WIDTH   = 18;
    localparam int C_DEF_NUM_OF_WEIGHTS = 4;

    // Index width for n items; a single item still needs one bit.
    function automatic int log2up(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int C_WIDX_WIDTH = log2up(C_DEF_NUM_OF_WEIGHTS);

    typedef logic signed [C_DEF_WEIGHT_WIDTH-1:0] weight_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/weights_responder_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// the pointer, which then moves just past the granted port.
module rr_arbiter
    import weights_pack::*;
#(
    parameter int G_N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [G_N-1:0] req,
    output logic [G_N-1:0] gnt
);

    localparam int C_PW = log2up(G_N);

    logic [C_PW-1:0] ptr;
    logic [C_PW-1:0] idx;
    logic            found;
    int              sum;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < G_N; i++) begin
            sum = int'(ptr) + i;
            if (sum >= G_N) begin
                sum = sum - G_N;
            end
            idx = C_PW'(sum);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            for (int p = 0; p < G_N; p++) begin
                if (gnt[p]) begin
                    ptr <= C_PW'(rr_next(p, G_N));
                end
            end
        end
    end

endmodule

// File: rtl/weights_responder.sv
// Avalon-MM responder holding one neuron's outgoing weights; serves reads
// from several ports round-robin, with weight updates stalling all reads.
module weights_responder
    import weights_pack::*;
#(
    parameter int G_WEIGHT_WIDTH   = C_DEF_WEIGHT_WIDTH,
    parameter int G_NUM_OF_WEIGHTS = C_DEF_NUM_OF_WEIGHTS,
    parameter int G_NUM_OF_PORTS   = 4,
    parameter int G_ADDR_WIDTH     = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [G_NUM_OF_PORTS*G_ADDR_WIDTH-1:0]   address,
    input  logic [G_NUM_OF_PORTS-1:0]                read,
    output logic [G_NUM_OF_PORTS-1:0]                waitreq,
    output logic [G_NUM_OF_PORTS*G_WEIGHT_WIDTH-1:0] read_data,
    output logic [G_NUM_OF_PORTS-1:0]                read_data_valid,
    input  logic                                     w_wr_valid,
    input  logic [log2up(G_NUM_OF_WEIGHTS)-1:0]      w_wr_idx,
    input  logic signed [G_WEIGHT_WIDTH-1:0]         w_wr_data,
    input  logic                                     irq_clr,
    output logic                                     irq_bad_addr
);

    localparam int C_IDX_W = log2up(G_NUM_OF_WEIGHTS);

    logic signed [G_WEIGHT_WIDTH-1:0] weights [G_NUM_OF_WEIGHTS];
    logic signed [G_WEIGHT_WIDTH-1:0] rd_q    [G_NUM_OF_PORTS];
    logic signed [G_WEIGHT_WIDTH-1:0] rd_mux  [G_NUM_OF_PORTS];
    logic [G_NUM_OF_PORTS-1:0]        gnt;
    logic [G_NUM_OF_PORTS-1:0]        addr_bad;
    logic                             wr_bad;

    rr_arbiter #(
        .G_N(G_NUM_OF_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (~w_wr_valid),
        .req    (read),
        .gnt    (gnt)
    );

    // Grants only go to requesters, so a grant is also an accepted transfer.
    assign waitreq = ~gnt;

    assign wr_bad = w_wr_valid &&
                    ({{(32-C_IDX_W){1'b0}}, w_wr_idx} >= 32'(G_NUM_OF_WEIGHTS));

    for (genvar p = 0; p < G_NUM_OF_PORTS; p++) begin : g_port
        logic [G_ADDR_WIDTH-1:0] addr;

        assign addr        = address[p*G_ADDR_WIDTH +: G_ADDR_WIDTH];
        assign addr_bad[p] = {{(32-G_ADDR_WIDTH){1'b0}}, addr} >= 32'(G_NUM_OF_WEIGHTS);
        assign rd_mux[p]   = addr_bad[p] ? '0 : weights[addr[C_IDX_W-1:0]];
        assign read_data[p*G_WEIGHT_WIDTH +: G_WEIGHT_WIDTH] = rd_q[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < G_NUM_OF_WEIGHTS; i++) begin
                weights[i] <= '0;
            end
        end else if (w_wr_valid && !wr_bad) begin
            weights[w_wr_idx] <= w_wr_data;
        end
    end

    // Non-granted ports keep their last data; only the valid strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_valid <= '0;
            for (int p = 0; p < G_NUM_OF_PORTS; p++) begin
                rd_q[p] <= '0;
            end
        end else begin
            read_data_valid <= gnt;
            for (int p = 0; p < G_NUM_OF_PORTS; p++) begin
                if (gnt[p]) begin
                    rd_q[p] <= rd_mux[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_bad_addr <= 1'b0;
        end else if (wr_bad || |(gnt & addr_bad)) begin
            irq_bad_addr <= 1'b1;
        end else if (irq_clr) begin
            irq_bad_addr <= 1'b0;
        end
    end

endmodule
